// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: central stall/flush controller for the 5-stage pipeline.
// Handles load-use bubbles, taken-branch flushes and data-memory waits, plus a
// memory-wait timeout that parks the pipeline in a sticky error state.
// Optional build macro HAZARD_PERF_EN adds stall/flush/load-use event counters.
module hazard_stall_ctrl #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_mem_branch_tk,
    input  logic                  i_mem_req,
    input  logic                  i_mem_ready,
    output logic                  o_pc_write,
    output logic                  o_ifid_write,
    output logic                  o_idex_write,
    output logic                  o_exmem_write,
    output logic                  o_memwb_write,
    output logic                  o_ifid_flush,
    output logic                  o_idex_flush,
    output logic                  o_exmem_flush,
    output logic                  o_mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]      o_stall_cycles,
    output logic [CNT_W-1:0]      o_flush_events,
    output logic [CNT_W-1:0]      o_load_use_events
`endif
);

    typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MEM_TIMEOUT);

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   w_wait_cnt_next;
    logic [CNT_W-1:0]   w_wait_cnt_inc;
    logic               w_load_use;
    logic               w_advance;

    // Load in EX feeding a source the ID instruction actually reads; x0 is never a hazard.
    assign w_load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                        ((i_id_uses_rs1 && (i_ex_rd == i_id_rs1)) ||
                         (i_id_uses_rs2 && (i_ex_rd == i_id_rs2)));

    // Saturating increment so a disabled timeout can wait forever without wrapping.
    assign w_wait_cnt_inc = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

    assign o_mem_err = (r_state == StErr);

    // State and wait counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StRun;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // Next-state logic and Mealy stage enables/flushes.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_advance       = 1'b0;
        o_pc_write      = 1'b0;
        o_ifid_write    = 1'b0;
        o_idex_write    = 1'b0;
        o_exmem_write   = 1'b0;
        o_memwb_write   = 1'b0;
        o_ifid_flush    = 1'b0;
        o_idex_flush    = 1'b0;
        o_exmem_flush   = 1'b0;

        if (i_reset) begin
            o_ifid_flush    = 1'b1;
            o_idex_flush    = 1'b1;
            o_exmem_flush   = 1'b1;
            w_state_next    = StRun;
            w_wait_cnt_next = '0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (i_mem_req && !i_mem_ready) begin
                        w_state_next    = StMemWait;
                        w_wait_cnt_next = CNT_W'(1);
                    end else begin
                        w_advance = 1'b1;
                    end
                end
                StMemWait: begin
                    if (i_mem_ready) begin
                        // Access completes: this cycle advances like a normal RUN cycle.
                        w_state_next    = StRun;
                        w_wait_cnt_next = '0;
                        w_advance       = 1'b1;
                    end else begin
                        w_wait_cnt_next = w_wait_cnt_inc;
                        if ((MEM_TIMEOUT != 0) && (w_wait_cnt_inc >= TimeoutCnt)) begin
                            w_state_next    = StErr;
                            w_wait_cnt_next = '0;
                        end
                    end
                end
                StErr: begin
                    w_state_next = StErr;
                end
                default: begin
                    w_state_next    = StRun;
                    w_wait_cnt_next = '0;
                end
            endcase

            if (w_advance) begin
                o_pc_write    = 1'b1;
                o_ifid_write  = 1'b1;
                o_idex_write  = 1'b1;
                o_exmem_write = 1'b1;
                o_memwb_write = 1'b1;
                if (i_mem_branch_tk) begin
                    // Branch resolved in MEM: kill the three younger instructions.
                    o_ifid_flush  = 1'b1;
                    o_idex_flush  = 1'b1;
                    o_exmem_flush = 1'b1;
                end else if (w_load_use) begin
                    // Hold PC/IFID one cycle and inject a single bubble into IDEX.
                    o_pc_write   = 1'b0;
                    o_ifid_write = 1'b0;
                    o_idex_flush = 1'b1;
                end
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic w_stall_evt;
    logic w_flush_evt;
    logic w_load_use_evt;

    assign w_stall_evt    = !i_reset && (r_state != StErr) && !o_pc_write;
    assign w_flush_evt    = !i_reset && w_advance && i_mem_branch_tk;
    assign w_load_use_evt = !i_reset && w_advance && !i_mem_branch_tk && w_load_use;

    // Free-running event counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_stall_cycles    <= '0;
            o_flush_events    <= '0;
            o_load_use_events <= '0;
        end else begin
            if (w_stall_evt)    o_stall_cycles    <= o_stall_cycles + CNT_W'(1);
            if (w_flush_evt)    o_flush_events    <= o_flush_events + CNT_W'(1);
            if (w_load_use_evt) o_load_use_events <= o_load_use_events + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios then random traffic,
// compared against a cycle-level behavioural model of the pipeline control rules.
module tb_hazard_stall_ctrl;

    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic       mem_branch_tk, mem_req, mem_ready;
    logic       pc_write, ifid_write, idex_write, exmem_write, memwb_write;
    logic       ifid_flush, idex_flush, exmem_flush, mem_err;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_events, load_use_events;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Model state: error flag, consecutive not-ready cycles of the outstanding access.
    bit          m_err  = 1'b0;
    int          m_pend = 0;
    logic [31:0] m_stall = '0, m_flush = '0, m_lu = '0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .REG_ADDR_W (5),
        .MEM_TIMEOUT(TIMEOUT),
        .CNT_W      (32)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_uses_rs1  (id_uses_rs1),
        .i_id_uses_rs2  (id_uses_rs2),
        .i_ex_mem_read  (ex_mem_read),
        .i_ex_rd        (ex_rd),
        .i_mem_branch_tk(mem_branch_tk),
        .i_mem_req      (mem_req),
        .i_mem_ready    (mem_ready),
        .o_pc_write     (pc_write),
        .o_ifid_write   (ifid_write),
        .o_idex_write   (idex_write),
        .o_exmem_write  (exmem_write),
        .o_memwb_write  (memwb_write),
        .o_ifid_flush   (ifid_flush),
        .o_idex_flush   (idex_flush),
        .o_exmem_flush  (exmem_flush),
        .o_mem_err      (mem_err)
`ifdef HAZARD_PERF_EN
        ,
        .o_stall_cycles   (stall_cycles),
        .o_flush_events   (flush_events),
        .o_load_use_events(load_use_events)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    // Output vector order: {pc, ifid, idex, exmem, memwb writes, ifid, idex, exmem flushes}.
    task automatic step(input string tag, input logic rst,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic mr, input logic [4:0] rd,
                        input logic br, input logic req, input logic rdy);
        logic [7:0] exp;
        logic       lu;
        logic       adv;
        reset = rst; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        ex_mem_read = mr; ex_rd = rd; mem_branch_tk = br; mem_req = req; mem_ready = rdy;
        #1;
        lu  = mr && (rd != 5'd0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
        adv = 1'b0;
        if (rst)                          exp = 8'b0000_0111;
        else if (m_err)                   exp = 8'b0000_0000;
        else if (!rdy && (m_pend > 0 || req)) exp = 8'b0000_0000;
        else begin
            adv = 1'b1;
            if (br)      exp = 8'b1111_1111;
            else if (lu) exp = 8'b0011_1010;
            else         exp = 8'b1111_1000;
        end
        chk({tag, ".ctl"}, {24'd0, pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                            ifid_flush, idex_flush, exmem_flush}, {24'd0, exp});
        if (!rst) chk({tag, ".err"}, {31'd0, mem_err}, {31'd0, m_err});
`ifdef HAZARD_PERF_EN
        if (!rst) begin
            chk({tag, ".stall"}, stall_cycles, m_stall);
            chk({tag, ".flush"}, flush_events, m_flush);
            chk({tag, ".lu"}, load_use_events, m_lu);
        end
`endif
        @(posedge clk);
        if (rst) begin
            m_err = 1'b0; m_pend = 0; m_stall = '0; m_flush = '0; m_lu = '0;
        end else if (!m_err) begin
            if (!adv) begin
                m_stall++;
                m_pend++;
                if (m_pend >= TIMEOUT) begin
                    m_err  = 1'b1;
                    m_pend = 0;
                end
            end else begin
                m_pend = 0;
                if (br) m_flush++;
                else if (lu) begin
                    m_lu++;
                    m_stall++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        step("rst0", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("rst1", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
        idle("idle");
        // ld x5; add x6,x5,x7 -> one bubble, then free flow
        step("lu_rs1", 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        step("lu_after", 1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1);
        // ld x0; add x6,x0,x1 -> no stall
        step("x0", 1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        // rs2 hazard, and rs2 match with uses_rs2 low
        step("lu_rs2", 1'b0, 5'd3, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
        step("nouse", 1'b0, 5'd3, 1'b1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
        // branch beats load-use
        step("br_lu", 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        // 3-cycle memory wait, then advance
        step("mw0", 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("mw1", 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("mw2", 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("mw3", 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        idle("mw_run");
        // wait ending with a load-use applied on the release cycle
        step("mwl0", 1'b0, 5'd4, 1'b1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0);
        step("mwl1", 1'b0, 5'd4, 1'b1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1);
        // reset in the middle of a wait
        step("mwr0", 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("mwr1", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle("mwr2");
        // timeout: never ready -> ERR, ready ignored there, reset clears
        for (int i = 0; i < TIMEOUT + 2; i++)
            step("to", 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("err_rdy", 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        step("err_rst", 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        idle("post_err");

        // Random traffic: small register range to provoke matches and x0 cases.
        for (int i = 0; i < 3000; i++) begin
            step("rnd", ($urandom_range(0, 79) == 0),
                 5'($urandom_range(0, 3)), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom),
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
